muladd_issue_ctrl: RTL and testbench

- Issue/sequencing controller for fused multiply-add instructions (rd = rs1*rs2 + rs3).
- Acts as the initiator on the rs3 selection interface. It drives the rs3 address candidate and the rs3 select code consumed by the rs3 source mux.
- Sequences the register-file read, the multiply-add unit (MAU) handshake and the writeback.
- Sits between decode and the register file / MAU.

---
 rtl/muladd_pkg.sv | 33 +++
 rtl/muladd_timeout_cnt.sv | 41 ++++
 rtl/muladd_issue_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_muladd_issue_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// Shared definitions for the fused multiply-add issue controller.
//   - Register address width and architectural register count.
//   - rs3 source-mux select codes (including codes owned by other issuers).
//   - Controller FSM state encoding.
//   - Helper to size the EXEC timeout counter.
package muladd_pkg;

  localparam int ADDR_WIDTH          = 5;
  localparam int NUMBER_OF_REGISTERS = 32;
  localparam int DATA_WIDTH          = 32;
  localparam int TIMEOUT_CYCLES      = 64;

  // rs3 source mux select codes. Only IDLE and MULADD are driven by this
  // controller; the others belong to other rs3 initiators sharing the mux.
  localparam logic [1:0] RS3_SEL_IDLE   = 2'b00;
  localparam logic [1:0] RS3_SEL_FWD    = 2'b01;
  localparam logic [1:0] RS3_SEL_MULADD = 2'b10;
  localparam logic [1:0] RS3_SEL_IMM    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4
  } state_t;

  // Bits needed to count 0 .. n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muladd_timeout_cnt.sv
// EXEC-phase watchdog for the multiply-add issue controller.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   run       - high while the controller sits in EXEC
//   expired   - high on the EXEC cycle whose count equals TIMEOUT-1
// The count is held at zero whenever run is low, so it always reads 0 on
// the first EXEC cycle and k on the (k+1)-th.
module muladd_timeout_cnt
  import muladd_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/muladd_issue_ctrl.sv
// Issue/sequencing controller for fused multiply-add (rd = rs1*rs2 + rs3).
// Accepts one instruction from decode, reads its three sources from the
// register file (driving the rs3 mux as the MULADD initiator), hands the
// operands to the multiply-add unit, and writes the result back.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   instr_valid / instr_ready     decode handshake (ready only in IDLE)
//   rd_in, rs1_in, rs2_in, rs3_in instruction register fields
//   rs1_addr, rs2_addr            register-file read addresses
//   rs3_muladd_cont, rs3_sel      rs3 address candidate and mux select
//   rf_re                         register-file read enable
//   rs1_data..rs3_data            read data, valid one cycle after rf_re
//   mau_start, op_a..op_c         MAU start pulse and held operands
//   mau_done, mau_result          MAU completion pulse and result
//   rf_we, rf_waddr, rf_wdata     writeback port
//   busy, timeout_err             status (timeout_err is sticky)
// Every output comes straight from a flop.
module muladd_issue_ctrl
  import muladd_pkg::*;
#(
  parameter int         ADDR_WIDTH = muladd_pkg::ADDR_WIDTH,
  parameter int         DATA_WIDTH = muladd_pkg::DATA_WIDTH,
  parameter logic [1:0] MULADD     = RS3_SEL_MULADD,
  parameter logic [1:0] IDLE_SEL   = RS3_SEL_IDLE,
  parameter int         TIMEOUT    = TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  input  logic [ADDR_WIDTH-1:0] rs1_in,
  input  logic [ADDR_WIDTH-1:0] rs2_in,
  input  logic [ADDR_WIDTH-1:0] rs3_in,
  output logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [ADDR_WIDTH-1:0] rs3_muladd_cont,
  output logic [1:0]            rs3_sel,
  output logic                  rf_re,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] rs3_data,
  output logic                  mau_start,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] op_c,
  input  logic                  mau_done,
  input  logic [DATA_WIDTH-1:0] mau_result,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy,
  output logic                  timeout_err
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] rs1_addr_q, rs1_addr_d;
  logic [ADDR_WIDTH-1:0] rs2_addr_q, rs2_addr_d;
  logic [ADDR_WIDTH-1:0] rs3_cont_q, rs3_cont_d;
  logic [1:0]            rs3_sel_q, rs3_sel_d;
  logic                  rf_re_q, rf_re_d;
  logic                  mau_start_q, mau_start_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] op_c_q, op_c_d;
  logic                  rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  instr_ready_q, instr_ready_d;

  logic exec_run;
  logic tmo_expired;

  assign exec_run = (state_q == ST_EXEC);

  muladd_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .run     (exec_run),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rs3_cont_d    = rs3_cont_q;
    rs3_sel_d     = rs3_sel_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_c_d        = op_c_q;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    timeout_err_d = timeout_err_q;
    // Strobes default low so each is high for exactly the one cycle
    // that follows the transition setting it.
    rf_re_d       = 1'b0;
    mau_start_d   = 1'b0;
    rf_we_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          rd_d          = rd_in;
          rs1_addr_d    = rs1_in;
          rs2_addr_d    = rs2_in;
          rs3_cont_d    = rs3_in;
          rs3_sel_d     = MULADD;
          rf_re_d       = 1'b1;
          timeout_err_d = 1'b0;
          state_d       = ST_READ;
        end
      end
      ST_READ: begin
        // Read data appears during CAPTURE; the mux select is released now.
        rs3_sel_d = IDLE_SEL;
        state_d   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        op_a_d      = rs1_data;
        op_b_d      = rs2_data;
        op_c_d      = rs3_data;
        mau_start_d = 1'b1;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        // A result arriving on the last allowed cycle still wins.
        if (mau_done) begin
          rf_wdata_d = mau_result;
          rf_waddr_d = rd_q;
          rf_we_d    = 1'b1;
          state_d    = ST_WB;
        end else if (tmo_expired) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d        = (state_d != ST_IDLE);
    instr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rd_q          <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rs3_cont_q    <= '0;
      rs3_sel_q     <= IDLE_SEL;
      rf_re_q       <= 1'b0;
      mau_start_q   <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_c_q        <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rs3_cont_q    <= rs3_cont_d;
      rs3_sel_q     <= rs3_sel_d;
      rf_re_q       <= rf_re_d;
      mau_start_q   <= mau_start_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_c_q        <= op_c_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  assign instr_ready     = instr_ready_q;
  assign rs1_addr        = rs1_addr_q;
  assign rs2_addr        = rs2_addr_q;
  assign rs3_muladd_cont = rs3_cont_q;
  assign rs3_sel         = rs3_sel_q;
  assign rf_re           = rf_re_q;
  assign mau_start       = mau_start_q;
  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign op_c            = op_c_q;
  assign rf_we           = rf_we_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign busy            = busy_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_muladd_issue_ctrl.sv
// Bench for muladd_issue_ctrl: register-file and MAU models, a writeback
// scoreboard, directed scenarios and a randomized instruction stream.
module tb_muladd_issue_ctrl;
  import muladd_pkg::*;

  localparam int AW  = muladd_pkg::ADDR_WIDTH;
  localparam int DW  = muladd_pkg::DATA_WIDTH;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [AW-1:0] rd_in = '0, rs1_in = '0, rs2_in = '0, rs3_in = '0;
  logic [AW-1:0] rs1_addr, rs2_addr, rs3_muladd_cont;
  logic [1:0]    rs3_sel;
  logic          rf_re;
  logic [DW-1:0] rs1_data = '0, rs2_data = '0, rs3_data = '0;
  logic          mau_start;
  logic [DW-1:0] op_a, op_b, op_c;
  logic          mau_done;
  logic          mau_done_m = 1'b0;
  logic          spur_done = 1'b0;
  logic [DW-1:0] mau_result = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          timeout_err;

  assign mau_done = mau_done_m | spur_done;

  muladd_issue_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MULADD     (2'b10),
    .IDLE_SEL   (2'b00),
    .TIMEOUT    (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .rd_in           (rd_in),
    .rs1_in          (rs1_in),
    .rs2_in          (rs2_in),
    .rs3_in          (rs3_in),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs3_muladd_cont (rs3_muladd_cont),
    .rs3_sel         (rs3_sel),
    .rf_re           (rf_re),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .rs3_data        (rs3_data),
    .mau_start       (mau_start),
    .op_a            (op_a),
    .op_b            (op_b),
    .op_c            (op_c),
    .mau_done        (mau_done),
    .mau_result      (mau_result),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    int            cyc;
  } wb_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    int            dly;   // cycles from mau_start to mau_done, -1 = never
  } mau_t;

  wb_t           wb_q[$];
  mau_t          mau_q[$];
  logic [DW-1:0] rf_m [0:(1<<AW)-1];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            last_wb_cyc = -100;
  int            rst_epoch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file: data for the addresses read under rf_re shows up one
  // cycle later; any other cycle carries random junk.
  logic          re_s;
  logic [AW-1:0] a1_s, a2_s, a3_s;
  initial begin : rf_read_model
    forever begin
      @(posedge clk);
      re_s = rf_re;
      a1_s = rs1_addr;
      a2_s = rs2_addr;
      a3_s = rs3_muladd_cont;
      #1;
      if (re_s === 1'b1) begin
        rs1_data = rf_m[a1_s];
        rs2_data = rf_m[a2_s];
        rs3_data = rf_m[a3_s];
      end else begin
        rs1_data = $urandom;
        rs2_data = $urandom;
        rs3_data = $urandom;
      end
    end
  end

  // MAU: checks the operands it is started with, answers after the delay
  // the stimulus asked for, gives up on a reset.
  initial begin : mau_model
    mau_t m;
    int   ep;
    bit   aborted;
    forever begin
      @(negedge clk);
      mau_done_m = 1'b0;
      mau_result = $urandom;
      if (mau_start === 1'b1 && rst === 1'b0) begin
        check("mau_start_expected", 64'(mau_q.size() != 0), 64'd1);
        if (mau_q.size() != 0) begin
          m = mau_q.pop_front();
          check("op_a", 64'(op_a), 64'(m.a));
          check("op_b", 64'(op_b), 64'(m.b));
          check("op_c", 64'(op_c), 64'(m.c));
          if (m.dly >= 0) begin
            ep = rst_epoch;
            aborted = 1'b0;
            for (int i = 0; i < m.dly; i++) begin
              @(negedge clk);
              mau_result = $urandom;
              if (rst_epoch != ep) begin
                aborted = 1'b1;
                break;
              end
            end
            if (!aborted) begin
              mau_done_m = 1'b1;
              mau_result = op_a * op_b + op_c;
              @(negedge clk);
              mau_done_m = 1'b0;
            end
          end
        end
      end
    end
  end

  // Writeback monitor / scoreboard.
  initial begin : wb_monitor
    wb_t e;
    bit  prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        check("rf_we_pulse_len", 64'(prev_we), 64'd0);
        check("wb_expected", 64'(wb_q.size() != 0), 64'd1);
        if (wb_q.size() != 0) begin
          e = wb_q.pop_front();
          check("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
          check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
          check("wb_cycle", 64'(cyc), 64'(e.cyc));
          rf_m[e.waddr] = e.wdata;
          last_wb_cyc = cyc;
        end
      end
      prev_we = (rf_we === 1'b1);
    end
  end

  // Present an instruction, wait (bounded) for acceptance, and record what
  // it must produce. Called and returns at a falling edge; on return the
  // instruction was accepted on the preceding rising edge.
  task automatic send(input logic [AW-1:0] rd, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                      input int dly, input bit hold_valid, input bit chk_b2b);
    int   guard = 0;
    mau_t m;
    wb_t  w;
    rd_in = rd; rs1_in = r1; rs2_in = r2; rs3_in = r3;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      check("accept_wait", 64'd0, 64'd1);
      instr_valid = 1'b0;
      return;
    end
    if (chk_b2b) check("b2b_accept_cycle", 64'(cyc), 64'(last_wb_cyc + 1));
    m.a = rf_m[r1]; m.b = rf_m[r2]; m.c = rf_m[r3]; m.dly = dly;
    mau_q.push_back(m);
    if (dly >= 0 && dly <= TMO - 1) begin
      w.waddr = rd;
      w.wdata = m.a * m.b + m.c;
      w.cyc   = cyc + 4 + dly;
      wb_q.push_back(w);
    end
    @(negedge clk);
    if (!hold_valid) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy !== 1'b0 || wb_q.size() != 0) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain_idle", 64'(g < 300), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [AW-1:0] rr, r1, r2, r3;
    bit            hold, prev_hold;
    for (int i = 0; i < (1 << AW); i++) rf_m[i] = $urandom;

    // Reset state.
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rf_re", 64'(rf_re), 64'd0);
    check("rst_mau_start", 64'(mau_start), 64'd0);
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_rs3_sel", 64'(rs3_sel), 64'd0);
    check("rst_addrs", 64'({rs1_addr, rs2_addr, rs3_muladd_cont, rf_waddr}), 64'd0);
    check("rst_data", 64'(op_a | op_b | op_c | rf_wdata), 64'd0);
    check("rst_ready", 64'(instr_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single instruction with cycle-accurate checks.
    rf_m[1] = 32'd4; rf_m[2] = 32'd6; rf_m[3] = 32'd7;
    send(5'd5, 5'd1, 5'd2, 5'd3, 1, 1'b0, 1'b0);
    check("t1_rf_re", 64'(rf_re), 64'd1);
    check("t1_rs3_sel_read", 64'(rs3_sel), 64'h2);
    check("t1_rs3_cont", 64'(rs3_muladd_cont), 64'd3);
    check("t1_rs1_addr", 64'(rs1_addr), 64'd1);
    check("t1_rs2_addr", 64'(rs2_addr), 64'd2);
    check("t1_ready_low", 64'(instr_ready), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_rf_re_off", 64'(rf_re), 64'd0);
    check("t1_rs3_sel_idle", 64'(rs3_sel), 64'd0);
    check("t1_no_start_yet", 64'(mau_start), 64'd0);
    @(negedge clk);
    check("t1_mau_start", 64'(mau_start), 64'd1);
    check("t1_ops", 64'({op_a[15:0], op_b[15:0], op_c[15:0]}), 64'h0004_0006_0007);
    @(negedge clk);
    check("t1_start_pulse", 64'(mau_start), 64'd0);
    @(negedge clk);
    check("t1_rf_we", 64'(rf_we), 64'd1);
    check("t1_wb", 64'({rf_waddr, rf_wdata}), 64'({5'd5, 32'd31}));
    @(negedge clk);
    check("t1_rf_we_off", 64'(rf_we), 64'd0);
    check("t1_idle_ready", 64'(instr_ready), 64'd1);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // MAU never answers: abort after TIMEOUT cycles in EXEC.
    send(5'd8, 5'd9, 5'd10, 5'd11, -1, 1'b0, 1'b0);
    repeat (TMO + 1) @(negedge clk);
    check("t2_err_not_early", 64'(timeout_err), 64'd0);
    check("t2_busy_last", 64'(busy), 64'd1);
    @(negedge clk);
    check("t2_timeout_err", 64'(timeout_err), 64'd1);
    check("t2_back_idle", 64'(busy), 64'd0);
    check("t2_ready", 64'(instr_ready), 64'd1);

    // Result on the final timeout cycle: writeback wins, error cleared.
    send(5'd12, 5'd13, 5'd14, 5'd15, TMO - 1, 1'b0, 1'b0);
    check("t3_err_cleared", 64'(timeout_err), 64'd0);
    repeat (TMO + 1) @(negedge clk);
    check("t3_still_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t3_wb_now", 64'(rf_we), 64'd1);
    @(negedge clk);
    check("t3_no_err", 64'(timeout_err), 64'd0);
    check("t3_idle", 64'(busy), 64'd0);

    // Asynchronous reset while in EXEC.
    send(5'd9, 5'd4, 5'd5, 5'd6, 20, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("t4_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    rst_epoch++;
    wb_q.delete();
    mau_q.delete();
    #1;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_strobes", 64'({rf_re, mau_start, rf_we, timeout_err}), 64'd0);
    check("t4_addrs", 64'({rs1_addr, rs2_addr, rs3_muladd_cont, rf_waddr}), 64'd0);
    check("t4_data", 64'(op_a | op_b | op_c | rf_wdata), 64'd0);
    check("t4_rs3_sel", 64'(rs3_sel), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t4_stays_idle", 64'(busy), 64'd0);
    send(5'd9, 5'd4, 5'd5, 5'd6, 2, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back with instr_valid held high; rd overlaps a source.
    send(5'd20, 5'd20, 5'd21, 5'd22, 1, 1'b1, 1'b0);
    send(5'd23, 5'd20, 5'd20, 5'd20, 1, 1'b0, 1'b1);
    wait_idle();

    // Spurious mau_done in IDLE and in READ.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_idle_we", 64'(rf_we), 64'd0);
    send(5'd24, 5'd25, 5'd26, 5'd27, 3, 1'b0, 1'b0);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("t6_read_progress", 64'({busy, rf_re, rf_we}), 64'b100);
    wait_idle();

    // Randomized stream.
    for (int i = 0; i < (1 << AW); i++) rf_m[i] = $urandom;
    prev_hold = 1'b0;
    for (int n = 0; n < 30; n++) begin
      rr = AW'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? rr : AW'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? rr : AW'($urandom);
      r3 = ($urandom_range(0, 3) == 0) ? rr : AW'($urandom);
      hold = (n != 29) && ($urandom_range(0, 1) == 1);
      send(rr, r1, r2, r3, int'($urandom_range(0, 8)), hold, prev_hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      prev_hold = hold;
    end
    wait_idle();
    check("sb_wb_empty", 64'(wb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
